// File: rtl/lcd_sw_pkg.sv
// Shared definitions for the front-panel LCD/switch SPI master: FSM states,
// chip-select codes and default frame/clock settings.
package lcd_sw_pkg;

  localparam int CLK_DIV_DEF = 50;
  localparam int DATA_W_DEF  = 24;

  localparam logic [2:0] CS_LCD = 3'd0;
  localparam logic [2:0] CS_SW  = 3'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_DONE
  } spi_state_t;

endpackage

// File: rtl/lcd_sw_spi_clkgen.sv
// Half-period counter for the SPI master: one tick every CLK_DIV enabled
// cycles, qualified into rising/falling SCLK strobes by the current SCLK level.
module lcd_sw_spi_clkgen
  import lcd_sw_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       sclk,
  output logic       tick,
  output logic       rise,
  output logic       fall,
  output logic [7:0] phase
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  // Counter restarts from zero whenever disabled so every phase is full length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tick  = en && (cnt == LAST);
  assign rise  = tick && !sclk;
  assign fall  = tick && sclk;
  assign phase = cnt;

endmodule

// File: rtl/lcd_sw_spi_master.sv
// 24-bit mode-3 SPI master for the US2066 OLED (CS0) and switch expander (CS1).
// Optional `SPI_MISO_SYNC_EN adds a 2-flop synchronizer on i_miso.
module lcd_sw_spi_master
  import lcd_sw_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_spi_start,
  input  logic [DATA_W-1:0] i_mosi_data,
  input  logic [2:0]        i_cs_sel,
  input  logic              i_miso,
  output logic              o_sclk,
  output logic              o_mosi,
  output logic [1:0]        o_cs_n,
  output logic [DATA_W-1:0] o_miso_data,
  output logic              o_busy,
  output logic              o_done,
  output spi_state_t        o_state
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  spi_state_t        state, state_nxt;
  logic [DATA_W-1:0] tx_sr, rx_sr, miso_q;
  logic [2:0]        sel_q;
  logic [BW-1:0]     bit_cnt;
  logic              sclk_q;
  logic              cnt_en, tick, rise, fall;
  logic [7:0]        phase;
  logic              miso_bit, sample;

  lcd_sw_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk   (i_clk),
    .rst_n (i_rst),
    .en    (cnt_en),
    .sclk  (sclk_q),
    .tick  (tick),
    .rise  (rise),
    .fall  (fall),
    .phase (phase)
  );

`ifdef SPI_MISO_SYNC_EN
  logic [1:0] miso_sync;
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) miso_sync <= '0;
    else        miso_sync <= {miso_sync[0], i_miso};
  end
  assign miso_bit = miso_sync[1];
  // Two cycles late, so the bit taken here is the one present in high-phase cycle 0.
  assign sample   = (state == ST_SHIFT) && sclk_q && (phase == 8'd2);
`else
  assign miso_bit = i_miso;
  assign sample   = (state == ST_SHIFT) && sclk_q && (phase == 8'd0);
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Start handshake: i_spi_start is taken only in IDLE (o_busy=0, o_done=0);
  // a request at any other time is dropped, never queued.
  always_comb begin
    state_nxt = state;
    cnt_en    = 1'b0;
    o_done    = 1'b0;
    unique case (state)
      ST_IDLE:     if (i_spi_start) state_nxt = ST_CS_SETUP;
      ST_CS_SETUP: begin
        cnt_en = 1'b1;
        if (tick) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        cnt_en = 1'b1;
        if (fall && bit_cnt == LAST_BIT) state_nxt = ST_CS_HOLD;
      end
      ST_CS_HOLD: begin
        cnt_en = 1'b1;
        if (tick) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        o_done    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      tx_sr   <= '0;
      rx_sr   <= '0;
      miso_q  <= '0;
      sel_q   <= '0;
      bit_cnt <= '0;
      sclk_q  <= 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: if (i_spi_start) begin
          tx_sr   <= i_mosi_data;
          sel_q   <= i_cs_sel;
          rx_sr   <= '0;
          bit_cnt <= '0;
        end
        ST_CS_SETUP: if (tick) sclk_q <= 1'b0;
        ST_SHIFT: begin
          if (sample) rx_sr <= {rx_sr[DATA_W-2:0], miso_bit};
          if (rise) sclk_q <= 1'b1;
          // The last high phase leaves SCLK high and MOSI on the final bit.
          if (fall && bit_cnt != LAST_BIT) begin
            sclk_q  <= 1'b0;
            tx_sr   <= {tx_sr[DATA_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_CS_HOLD: if (tick) miso_q <= rx_sr;
        default: ;
      endcase
    end
  end

  assign o_busy      = cnt_en;
  assign o_sclk      = sclk_q;
  assign o_mosi      = tx_sr[DATA_W-1];
  assign o_miso_data = miso_q;
  assign o_state     = state;
  assign o_cs_n      = !cnt_en           ? 2'b11 :
                       (sel_q == CS_LCD) ? 2'b10 :
                       (sel_q == CS_SW)  ? 2'b01 : 2'b11;

endmodule

// File: tb/tb_lcd_sw_spi_master.sv
// Self-checking bench for lcd_sw_spi_master: directed bus scenarios plus
// randomized frames against a bit-level slave model and expected-word queue.
module tb_lcd_sw_spi_master;
  import lcd_sw_pkg::*;

`ifdef SPI_MISO_SYNC_EN
  localparam int CD = 3;
`else
  localparam int CD = 2;
`endif
  localparam int DW  = 24;
  localparam int LAT = (2 * DW + 2) * CD;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          spi_start = 1'b0;
  logic [DW-1:0] mosi_data = '0;
  logic [2:0]    cs_sel = '0;
  logic          miso, sclk, mosi, busy, done;
  logic [1:0]    cs_n;
  logic [DW-1:0] miso_data;
  spi_state_t    state;

  always #5 clk = ~clk;

  lcd_sw_spi_master #(.CLK_DIV(CD), .DATA_W(DW)) dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_spi_start (spi_start),
    .i_mosi_data (mosi_data),
    .i_cs_sel    (cs_sel),
    .i_miso      (miso),
    .o_sclk      (sclk),
    .o_mosi      (mosi),
    .o_cs_n      (cs_n),
    .o_miso_data (miso_data),
    .o_busy      (busy),
    .o_done      (done),
    .o_state     (state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_tx;
  logic [1:0]    mon_cs = 2'b11;
  int            k_edge;
  bit            loop_mode = 1'b1;
  logic [DW-1:0] slave_word = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_cs(input logic [2:0] sel);
    if (sel == 3'd0) return 2'b10;
    if (sel == 3'd1) return 2'b01;
    return 2'b11;
  endfunction

  // ---------------- monitor + mode-3 slave ----------------
  logic          prev_sclk = 1'b1, prev_busy = 1'b0, slave_bit = 1'b0;
  logic          rise_bits[$];
  int            cs_bad = 0, done_cnt = 0, done_cyc = 0, first_busy = 0, falls = 0;
  logic [1:0]    done_cs;
  logic          done_busy;
  logic [DW-1:0] done_data;

  assign miso = loop_mode ? mosi : slave_bit;

  always @(negedge clk) begin
    if (busy && !prev_busy) begin
      rise_bits.delete();
      cs_bad     = 0;
      done_cnt   = 0;
      falls      = 0;
      first_busy = cyc;
    end
    if (!prev_sclk && sclk) rise_bits.push_back(mosi);
    if (prev_sclk && !sclk) begin
      falls++;
      if (falls <= DW) slave_bit = slave_word[DW-falls];
    end
    if (busy && cs_n !== mon_cs) cs_bad++;
    if (done) begin
      done_cnt++;
      done_cyc  = cyc;
      done_cs   = cs_n;
      done_busy = busy;
      done_data = miso_data;
    end
    prev_sclk = sclk;
    prev_busy = busy;
  end

  // ---------------- driver tasks ----------------
  // Called half a cycle before the edge that samples the start.
  task automatic start_frame(input logic [DW-1:0] d, input logic [2:0] sel,
                             input bit loop, input logic [DW-1:0] sw);
    loop_mode  = loop;
    slave_word = sw;
    mon_cs     = exp_cs(sel);
    exp_tx     = d;
    exp_q.push_back(loop ? d : sw);
    spi_start  = 1'b1;
    mosi_data  = d;
    cs_sel     = sel;
    k_edge     = cyc + 1;
    @(negedge clk); #1;
    spi_start  = 1'b0;
    mosi_data  = DW'($urandom);
    cs_sel     = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < LAT + 20) begin
      @(negedge clk); #1;
      n++;
    end
    check($sformatf("%s_done_seen", tag), 32'(done_cnt != 0), 32'd1);
  endtask

  task automatic check_frame(input string tag);
    logic [DW-1:0] got_tx, exp_rx;
    got_tx = '0;
    foreach (rise_bits[i]) got_tx = {got_tx[DW-2:0], rise_bits[i]};
    exp_rx = exp_q.pop_front();
    check($sformatf("%s_busy_start", tag), 32'(first_busy), 32'(k_edge));
    check($sformatf("%s_latency", tag), 32'(done_cyc - k_edge), 32'(LAT));
    check($sformatf("%s_sclk_rises", tag), 32'(rise_bits.size()), 32'(DW));
    check($sformatf("%s_mosi_word", tag), 32'(got_tx), 32'(exp_tx));
    check($sformatf("%s_cs_frame", tag), 32'(cs_bad), 32'd0);
    check($sformatf("%s_cs_done", tag), 32'(done_cs), 32'b11);
    check($sformatf("%s_busy_done", tag), 32'(done_busy), 32'd0);
    check($sformatf("%s_miso_word", tag), 32'(done_data), 32'(exp_rx));
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk); #1;
    check($sformatf("%s_idle_done", tag), 32'(done), 32'd0);
    check($sformatf("%s_idle_busy", tag), 32'(busy), 32'd0);
    check($sformatf("%s_idle_cs", tag), 32'(cs_n), 32'b11);
    check($sformatf("%s_idle_sclk", tag), 32'(sclk), 32'd1);
  endtask

  task automatic reset_values(input string tag);
    check($sformatf("%s_sclk", tag), 32'(sclk), 32'd1);
    check($sformatf("%s_mosi", tag), 32'(mosi), 32'd0);
    check($sformatf("%s_cs_n", tag), 32'(cs_n), 32'b11);
    check($sformatf("%s_miso_data", tag), 32'(miso_data), 32'd0);
    check($sformatf("%s_busy", tag), 32'(busy), 32'd0);
    check($sformatf("%s_done", tag), 32'(done), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e1, n;
    #2 rst_n = 1'b0;
    #1 reset_values("por");
    check("por_state", 32'(state), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // LCD frame, independent slave data
    start_frame(24'hF8_50_40, 3'd0, 1'b0, 24'h3C_96_E1);
    wait_done("lcd");
    check_frame("lcd");
    idle_check("lcd");

    // switch frame, loopback
    start_frame(24'hA5_3C_0F, 3'd1, 1'b1, '0);
    wait_done("loop");
    check_frame("loop");
    idle_check("loop");

    // second start in the middle of SHIFT is dropped
    start_frame(24'h12_34_56, 3'd0, 1'b1, '0);
    repeat (CD * 10) @(negedge clk);
    #1 spi_start = 1'b1; mosi_data = 24'hED_CB_A9; cs_sel = 3'd1;
    @(negedge clk); #1 spi_start = 1'b0;
    wait_done("midstart");
    check_frame("midstart");
    repeat (LAT + 5) @(negedge clk);
    #1 check("midstart_single_done", 32'(done_cnt), 32'd1);

    // back-to-back: start in the IDLE cycle right after DONE
    start_frame(24'h0F_F0_55, 3'd1, 1'b0, 24'hC3_5A_81);
    wait_done("b2b_a");
    check_frame("b2b_a");
    e1 = done_cyc;
    @(negedge clk); #1;
    start_frame(24'h81_7E_24, 3'd0, 1'b1, '0);
    check("b2b_idle_gap", 32'(first_busy - e1), 32'd2);
    wait_done("b2b_b");
    check_frame("b2b_b");

    // start during DONE is ignored
    #0 spi_start = 1'b1;
    @(negedge clk); #1 spi_start = 1'b0;
    check("done_start_ignored", 32'(busy), 32'd0);
    @(negedge clk); #1;
    check("done_start_still_idle", 32'(busy), 32'd0);

    // reset at bit 10 aborts immediately
    start_frame(24'hFF_FF_FF, 3'd0, 1'b0, 24'hFF_FF_FF);
    n = 0;
    while (rise_bits.size() < 10 && n < LAT) begin
      @(negedge clk); #1;
      n++;
    end
    check("rst_reached_bit10", 32'(rise_bits.size()), 32'd10);
    rst_n = 1'b0;
    #1 reset_values("abort");
    void'(exp_q.pop_back());
    @(negedge clk); #1 rst_n = 1'b1;
    @(negedge clk); #1 check("abort_miso_kept0", 32'(miso_data), 32'd0);
    start_frame(24'h5A_A5_C3, 3'd1, 1'b0, 24'h69_96_0F);
    wait_done("post_rst");
    check_frame("post_rst");
    idle_check("post_rst");

    // no-device select: bus timing runs, CS stays high
    start_frame(24'hDE_AD_BE, 3'd5, 1'b0, 24'h13_57_9B);
    wait_done("nocs");
    check_frame("nocs");
    idle_check("nocs");

    // randomized frames
    for (int i = 0; i < 6; i++) begin
      start_frame(DW'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), DW'($urandom));
      wait_done($sformatf("rnd%0d", i));
      check_frame($sformatf("rnd%0d", i));
      idle_check($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
